// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback/commit stage: datapath width,
// register file geometry, state encoding and the exit-code register index.
package wb_stage_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    localparam logic [4:0] REG_A0 = 5'd10;

    typedef enum logic {
        WB_RUN    = 1'b0,
        WB_HALTED = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_regfile_2r1w.sv
// Integer register file: NREG x XLEN, one write port, two combinational read
// ports plus a fixed tap, all with x0 = 0 and same-cycle write bypass.
module regfile_2r1w
    import wb_stage_pkg::*;
#(
    parameter logic [4:0] TAP_REG = REG_A0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            wen,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic [XLEN-1:0] tap_data
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0)                ? '0    :
                    (wen && waddr == raddr1)        ? wdata :
                                                      regs[raddr1];

    assign rdata2 = (raddr2 == 5'd0)                ? '0    :
                    (wen && waddr == raddr2)        ? wdata :
                                                      regs[raddr2];

    // Post-write view of one register, used to capture the exit code.
    assign tap_data = (wen && waddr == TAP_REG) ? wdata : regs[TAP_REG];

endmodule

// File: rtl/wb_stage.sv
// Writeback/commit stage: accept gating, register file writes, commit record,
// retired-instruction counter and the run/halt state machine.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WB_RUN    | accepting instructions from the memory stage
// WB_HALTED | exit instruction retired; all input ignored until reset
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            valid_i,
    input  logic            rf_wen_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] rf_wdata_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            exit_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            commit_valid_o,
    output logic [XLEN-1:0] commit_pc_o,
    output logic [XLEN-1:0] retired_o,
    output logic            halted_o,
    output logic [XLEN-1:0] exit_code_o
);

    wb_state_e       state, state_nxt;
    logic            acc;
    logic            halt_now;
    logic [XLEN-1:0] a0_post;

    assign acc      = valid_i && (state == WB_RUN);
    assign halt_now = acc && exit_i;

    regfile_2r1w #(.TAP_REG(REG_A0)) u_regfile (
        .clock    (clock),
        .reset_n  (reset_n),
        .wen      (acc && rf_wen_i),
        .waddr    (rd_i),
        .wdata    (rf_wdata_i),
        .raddr1   (rs1_i),
        .raddr2   (rs2_i),
        .rdata1   (rs1_data_o),
        .rdata2   (rs2_data_o),
        .tap_data (a0_post)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= WB_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_RUN:    if (halt_now) state_nxt = WB_HALTED;
            WB_HALTED: state_nxt = WB_HALTED;
            default:   state_nxt = WB_RUN;
        endcase
    end

    assign halted_o = (state == WB_HALTED);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            commit_valid_o <= 1'b0;
            commit_pc_o    <= '0;
            retired_o      <= '0;
            exit_code_o    <= '0;
        end else begin
            commit_valid_o <= acc;
            if (acc) begin
                commit_pc_o <= pc_i;
                retired_o   <= retired_o + 1'b1;
            end
            // The exit instruction's own a0 write is visible in the captured code.
            if (halt_now) begin
                exit_code_o <= a0_post;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: writeback, bypass, x0, bubbles, halt and
// asynchronous reset, each against hand-computed expected values.
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        valid_i;
    logic        rf_wen_i;
    logic [4:0]  rd_i;
    logic [63:0] rf_wdata_i;
    logic [63:0] pc_i;
    logic        exit_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [63:0] rs1_data_o;
    logic [63:0] rs2_data_o;
    logic        commit_valid_o;
    logic [63:0] commit_pc_o;
    logic [63:0] retired_o;
    logic        halted_o;
    logic [63:0] exit_code_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    wb_stage dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .valid_i        (valid_i),
        .rf_wen_i       (rf_wen_i),
        .rd_i           (rd_i),
        .rf_wdata_i     (rf_wdata_i),
        .pc_i           (pc_i),
        .exit_i         (exit_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .rs1_data_o     (rs1_data_o),
        .rs2_data_o     (rs2_data_o),
        .commit_valid_o (commit_valid_o),
        .commit_pc_o    (commit_pc_o),
        .retired_o      (retired_o),
        .halted_o       (halted_o),
        .exit_code_o    (exit_code_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wen, input logic [4:0] rd,
                         input logic [63:0] wdata, input logic [63:0] pc, input logic ex);
        valid_i    = v;
        rf_wen_i   = wen;
        rd_i       = rd;
        rf_wdata_i = wdata;
        pc_i       = pc;
        exit_i     = ex;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic to_negedge();
        @(negedge clock);
    endtask

    task automatic fresh_reset();
        to_negedge();
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        rs1_i   = 5'd0;
        rs2_i   = 5'd0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_commit_valid", {63'd0, commit_valid_o}, 64'd0);
        chk("rst_commit_pc",    commit_pc_o, 64'd0);
        chk("rst_retired",      retired_o,   64'd0);
        chk("rst_halted",       {63'd0, halted_o}, 64'd0);
        chk("rst_exit_code",    exit_code_o, 64'd0);

        // Write x5 with same-cycle bypass
        to_negedge();
        reset_n = 1'b1;
        drive(1, 1, 5'd5, 64'hDEAD_BEEF, 64'h8000_0000, 0);
        rs1_i = 5'd5;
        rs2_i = 5'd0;
        #1;
        chk("bypass_rs1", rs1_data_o, 64'hDEAD_BEEF);
        chk("rs2_x0",     rs2_data_o, 64'd0);
        tick();
        chk("wr_commit_valid", {63'd0, commit_valid_o}, 64'd1);
        chk("wr_commit_pc",    commit_pc_o, 64'h8000_0000);
        chk("wr_retired",      retired_o,   64'd1);

        // Bubble carrying a write to x7
        to_negedge();
        drive(0, 1, 5'd7, 64'h55, 64'h8000_0004, 0);
        rs2_i = 5'd7;
        #1;
        chk("x5_stored",     rs1_data_o, 64'hDEAD_BEEF);
        chk("bubble_no_byp", rs2_data_o, 64'd0);
        tick();
        chk("bubble_commit_valid", {63'd0, commit_valid_o}, 64'd0);
        chk("bubble_retired",      retired_o,   64'd1);
        chk("bubble_pc_hold",      commit_pc_o, 64'h8000_0000);
        chk("bubble_x7",           rs2_data_o,  64'd0);

        // Write to x0 is dropped but still retires
        to_negedge();
        drive(1, 1, 5'd0, 64'h1234, 64'h8000_0004, 0);
        rs1_i = 5'd0;
        #1;
        chk("x0_same_cycle", rs1_data_o, 64'd0);
        tick();
        chk("x0_after",   rs1_data_o, 64'd0);
        chk("x0_retired", retired_o,  64'd2);

        // a0 = 42, then exit
        to_negedge();
        drive(1, 1, 5'd10, 64'd42, 64'h8000_0008, 0);
        tick();
        chk("a0_retired", retired_o, 64'd3);
        to_negedge();
        drive(1, 0, 5'd0, 64'd0, 64'h8000_0010, 1);
        tick();
        chk("halt_halted",       {63'd0, halted_o}, 64'd1);
        chk("halt_exit_code",    exit_code_o, 64'd42);
        chk("halt_commit_pc",    commit_pc_o, 64'h8000_0010);
        chk("halt_commit_valid", {63'd0, commit_valid_o}, 64'd1);
        chk("halt_retired",      retired_o,   64'd4);

        // Everything ignored once halted; reads still work
        to_negedge();
        drive(1, 1, 5'd3, 64'd9, 64'h8000_0014, 0);
        rs1_i = 5'd3;
        rs2_i = 5'd10;
        #1;
        chk("halted_no_byp", rs1_data_o, 64'd0);
        tick();
        chk("halted_x3",           rs1_data_o, 64'd0);
        chk("halted_read_a0",      rs2_data_o, 64'd42);
        chk("halted_retired",      retired_o,  64'd4);
        chk("halted_commit_valid", {63'd0, commit_valid_o}, 64'd0);
        chk("halted_commit_pc",    commit_pc_o, 64'h8000_0010);
        chk("halted_sticky",       {63'd0, halted_o}, 64'd1);

        // Exit instruction that writes a0 itself
        fresh_reset();
        chk("rst2_halted", {63'd0, halted_o}, 64'd0);
        chk("rst2_a0",     rs2_data_o, 64'd0);
        to_negedge();
        drive(1, 1, 5'd10, 64'd7, 64'h100, 1);
        tick();
        chk("exit_a0_code",    exit_code_o, 64'd7);
        chk("exit_a0_halted",  {63'd0, halted_o}, 64'd1);
        chk("exit_a0_retired", retired_o, 64'd1);
        chk("exit_a0_reg",     rs2_data_o, 64'd7);

        // Async reset mid-run after three commits
        fresh_reset();
        for (int i = 0; i < 3; i++) begin
            to_negedge();
            drive(1, 1, 5'(5 + i), 64'h70 + 64'(i), 64'h200 + 64'(4 * i), 0);
            tick();
        end
        chk("run3_retired", retired_o, 64'd3);
        rs1_i = 5'd5;
        to_negedge();
        drive(1, 1, 5'd5, 64'hAA, 64'h300, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_commit_valid", {63'd0, commit_valid_o}, 64'd0);
        chk("arst_commit_pc",    commit_pc_o, 64'd0);
        chk("arst_retired",      retired_o,   64'd0);
        chk("arst_halted",       {63'd0, halted_o}, 64'd0);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("arst_x5", rs1_data_o, 64'd0);
        tick();
        chk("arst_held_retired", retired_o, 64'd0);
        to_negedge();
        reset_n = 1'b1;
        drive(1, 0, 5'd0, 64'd0, 64'h400, 0);
        tick();
        chk("post_rst_run_retired", retired_o,   64'd1);
        chk("post_rst_run_pc",      commit_pc_o, 64'h400);
        chk("post_rst_x5",          rs1_data_o,  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback/commit stage directly downstream of the memory stage.
- Consumes the memory stage's rf_wen/rd/rf_wdata/pc/exit outputs, qualified by a valid bit.
- Owns the 32x64 integer register file and serves the decode stage through two read ports with same-cycle write bypass.
- Tracks retired instructions, registers the last commit for the DPI/difftest harness, and runs the halt state machine on exit.

Parameters:
- XLEN, 64, datapath width.
- NREG, 32, architectural register count; x0 is hardwired to zero.
- EXIT_REG, 10, index of the register reported as exit code (a0).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  memory-stage slot holds a real instruction (0 = bubble).
- rf_wen_i  in  1  write enable from memory stage.
- rd_i  in  5  destination register.
- rf_wdata_i  in  XLEN  write data (load data or ALU result).
- pc_i  in  XLEN  PC of the instruction in this slot.
- exit_i  in  1  instruction is the simulation-exit instruction (ebreak).
- rs1_i  in  5  read address, port 1.
- rs2_i  in  5  read address, port 2.
- rs1_data_o  out  XLEN  read data, port 1 (combinational).
- rs2_data_o  out  XLEN  read data, port 2 (combinational).
- commit_valid_o  out  1  one-cycle pulse: an instruction retired last cycle.
- commit_pc_o  out  XLEN  PC of the last retired instruction.
- retired_o  out  XLEN  count of retired instructions.
- halted_o  out  1  halt state reached; sticky until reset.
- exit_code_o  out  XLEN  value of EXIT_REG captured at halt.

Behaviour:
- Reset, asynchronous on reset_n=0, takes effect immediately regardless of clock:
  - all registers 0, state RUN, retired_o=0;
  - commit_valid_o=0, commit_pc_o=0, halted_o=0, exit_code_o=0.
  - Reset asserted mid-operation discards any in-flight write.
- Accept condition: acc = valid_i & (state==RUN). Every input is ignored when acc=0.
- Register write: on posedge, if acc & rf_wen_i & rd_i!=0, then reg[rd_i] <= rf_wdata_i. Writes to x0 are dropped silently.
- Read ports, per port:
  - addr==0 -> 0;
  - else if acc & rf_wen_i & rd_i==addr -> rf_wdata_i (bypass);
  - else reg[addr].
  - Pure combinational, zero latency.
- Commit, on posedge with acc=1:
  - commit_valid_o<=1, commit_pc_o<=pc_i, retired_o<=retired_o+1.
  - retired_o wraps modulo 2^XLEN.
  - When acc=0, commit_valid_o<=0 and commit_pc_o holds.
- State machine: two states, RUN and HALTED.
  - RUN -> HALTED on posedge with acc & exit_i.
  - The exit instruction itself retires: it counts, pulses commit_valid_o, and performs its own register write if rf_wen_i=1.
  - exit_code_o <= post-write value of EXIT_REG, i.e. rf_wdata_i if the same instruction writes EXIT_REG, else reg[EXIT_REG].
  - HALTED is terminal until reset: no writes, no commits, counter frozen.
  - halted_o = (state==HALTED), registered.
  - Read ports stay functional in HALTED so the harness can dump state.
- Bubble with rf_wen_i=1 or exit_i=1 (valid_i=0): no effect.

Decomposition:
- Shared package (existing defines file):
  - XLEN;
  - wb state encoding (WB_RUN=1'b0, WB_HALTED=1'b1);
  - REG_A0 = 5'd10.
- Sub-module regfile_2r1w: 32xXLEN storage, async reset, one write port, two combinational read ports with x0=0 and write bypass.
- wb_stage keeps the accept logic, commit registers, counter and FSM.

Test Plan:
- Write/readback: valid, wen, rd=5, wdata=0xDEAD_BEEF -> same cycle rs1_data_o=0xDEAD_BEEF (bypass); next cycle still 0xDEAD_BEEF; retired_o=1; commit_pc_o=pc_i.
- x0 write: wen, rd=0, wdata=0x1234 -> rs1_i=0 reads 0 in that cycle and after; retired_o still increments.
- Bubble: valid_i=0, wen=1, rd=7, wdata=0x55 -> reg7 stays 0; commit_valid_o=0; retired_o unchanged.
- Halt: write x10=42, then exit_i with pc=0x8000_0010 -> halted_o=1, exit_code_o=42, commit_pc_o=0x8000_0010; later valid write to x3=9 is ignored and retired_o frozen.
- Exit writing a0: exit_i & wen & rd=10 & wdata=7 in the same beat -> exit_code_o=7.
- Async reset mid-run: after 3 commits, pulse reset_n low between clock edges -> outputs clear immediately; reg5 reads 0; state RUN.
